// File: rtl/xmuladd.sv
// xmuladd: pipelined multiply / multiply-accumulate functional unit.
// Two operands are picked from the flow bus, multiplied through PIPE product
// stages, then either streamed (MUL_LO / MUL_HI) or accumulated per period
// (MAC / MSUB). A run/done handshake frames each run.
// Optional build macro: XMULADD_SAT_EN saturates the shifted result to DATA_W
// instead of wrapping it.
//
// Handshake: run is a one-cycle request honoured only while the FSM is IDLE
// (it latches every conf_* input on that edge); done is a one-cycle pulse that
// is high in exactly the cycle the run's final flow_out value first appears.
// dbg_state exposes the FSM state (0 IDLE, 1 DELAY, 2 RUN, 3 DRAIN).
module xmuladd #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 16,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 10,
    parameter int PIPE   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    output logic                      done,
    input  logic [N_SRC*DATA_W-1:0]   flow_in,
    output logic [DATA_W-1:0]         flow_out,
    input  logic [SEL_W-1:0]          conf_sela,
    input  logic [SEL_W-1:0]          conf_selb,
    input  logic [1:0]                conf_fns,
    input  logic [5:0]                conf_shift,
    input  logic [CNT_W-1:0]          conf_per,
    input  logic [CNT_W-1:0]          conf_iter,
    input  logic [CNT_W-1:0]          conf_delay,
    output logic [1:0]                dbg_state
);

    localparam int PW = 2 * DATA_W;
    localparam logic [2:0] DRAIN_LAST = 3'(PIPE + 1);
    localparam logic [7:0] HI_OFF     = 8'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DRAIN} state_t;
    typedef enum logic [1:0] {FN_LO, FN_HI, FN_MAC, FN_MSUB} fn_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [2:0]       drain_cnt_q, drain_cnt_d;
    logic             done_q, done_d;
    logic             cfg_load;
    logic             smp_v, smp_first, smp_last;

    // latched configuration
    logic [SEL_W-1:0] sela_q, selb_q;
    fn_t              fns_q;
    logic [5:0]       shift_q;
    logic [CNT_W-1:0] per_q, iter_q;

    // datapath
    logic [DATA_W-1:0]    src [N_SRC];
    logic [DATA_W-1:0]    opa_q, opb_q;
    logic                 op_v_q, op_first_q, op_last_q;
    logic signed [PW-1:0] a_ext, b_ext, prod;
    logic signed [PW-1:0] p_q [PIPE];
    logic [PIPE-1:0]      pv_q, pf_q, pl_q;
    logic signed [PW-1:0] p_last;
    logic signed [PW-1:0] acc_q, acc_d;
    logic                 acc_v_q, acc_last_q;
    logic [7:0]           sh_amt;
    logic [DATA_W-1:0]    res;
    logic [DATA_W-1:0]    flow_out_q;
    logic                 out_upd;

    assign done      = done_q;
    assign flow_out  = flow_out_q;
    assign dbg_state = state_q;

    // FSM state and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            per_cnt_q   <= '0;
            iter_cnt_q  <= '0;
            delay_cnt_q <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            iter_cnt_q  <= iter_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    // FSM next state, counters, sample strobe and done pulse
    always_comb begin
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        iter_cnt_d  = iter_cnt_q;
        delay_cnt_d = delay_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        cfg_load    = 1'b0;
        smp_v       = 1'b0;
        smp_first   = (per_cnt_q == '0);
        smp_last    = (per_cnt_q == per_q - CNT_W'(1));
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    cfg_load    = 1'b1;
                    per_cnt_d   = '0;
                    iter_cnt_d  = '0;
                    drain_cnt_d = '0;
                    delay_cnt_d = conf_delay;
                    if (conf_delay != '0)
                        state_d = S_DELAY;
                    else if (conf_per == '0 || conf_iter == '0)
                        state_d = S_DRAIN;
                    else
                        state_d = S_RUN;
                end
            end
            S_DELAY: begin
                delay_cnt_d = delay_cnt_q - CNT_W'(1);
                if (delay_cnt_q == CNT_W'(1))
                    state_d = (per_q == '0 || iter_q == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                smp_v = 1'b1;
                if (smp_last) begin
                    per_cnt_d = '0;
                    if (iter_cnt_q == iter_q - CNT_W'(1))
                        state_d = S_DRAIN;
                    else
                        iter_cnt_d = iter_cnt_q + CNT_W'(1);
                end else begin
                    per_cnt_d = per_cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                // the last sample needs PIPE+2 edges to reach flow_out
                if (drain_cnt_q == DRAIN_LAST) begin
                    done_d      = 1'b1;
                    drain_cnt_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // configuration latch, loaded only when a run is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sela_q  <= '0;
            selb_q  <= '0;
            fns_q   <= FN_LO;
            shift_q <= '0;
            per_q   <= '0;
            iter_q  <= '0;
        end else if (cfg_load) begin
            sela_q  <= conf_sela;
            selb_q  <= conf_selb;
            fns_q   <= fn_t'(conf_fns);
            shift_q <= conf_shift;
            per_q   <= conf_per;
            iter_q  <= conf_iter;
        end
    end

    // split the flow bus into addressable sources
    always_comb begin
        for (int i = 0; i < N_SRC; i++) src[i] = flow_in[i*DATA_W +: DATA_W];
    end

    // operand registers: one sample per RUN cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opa_q      <= '0;
            opb_q      <= '0;
            op_v_q     <= 1'b0;
            op_first_q <= 1'b0;
            op_last_q  <= 1'b0;
        end else begin
            op_v_q     <= smp_v;
            op_first_q <= smp_first;
            op_last_q  <= smp_last;
            if (smp_v) begin
                opa_q <= src[sela_q];
                opb_q <= src[selb_q];
            end
        end
    end

    assign a_ext  = {{DATA_W{opa_q[DATA_W-1]}}, opa_q};
    assign b_ext  = {{DATA_W{opb_q[DATA_W-1]}}, opb_q};
    assign prod   = a_ext * b_ext;
    assign p_last = p_q[PIPE-1];

    // product pipeline: PIPE stages carrying product, valid, first and last flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE; i++) p_q[i] <= '0;
            pv_q <= '0;
            pf_q <= '0;
            pl_q <= '0;
        end else begin
            p_q[0]  <= prod;
            pv_q[0] <= op_v_q;
            pf_q[0] <= op_first_q;
            pl_q[0] <= op_last_q;
            for (int i = 1; i < PIPE; i++) begin
                p_q[i]  <= p_q[i-1];
                pv_q[i] <= pv_q[i-1];
                pf_q[i] <= pf_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
        end
    end

    // accumulator next value; a period restarts on its first product
    always_comb begin
        acc_d = acc_q;
        case (fns_q)
            FN_MAC:  acc_d = pf_q[PIPE-1] ? p_last : acc_q + p_last;
            FN_MSUB: acc_d = pf_q[PIPE-1] ? -p_last : acc_q - p_last;
            default: acc_d = p_last;
        endcase
    end

    // accumulator stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            acc_v_q    <= 1'b0;
            acc_last_q <= 1'b0;
        end else begin
            acc_v_q    <= pv_q[PIPE-1];
            acc_last_q <= pl_q[PIPE-1];
            if (pv_q[PIPE-1]) acc_q <= acc_d;
        end
    end

    // scale the accumulator down to DATA_W; MUL_HI treats operands as Q(DATA_W-1)
    always_comb begin
        sh_amt = (fns_q == FN_HI) ? HI_OFF + {2'b00, shift_q} : {2'b00, shift_q};
`ifdef XMULADD_SAT_EN
        begin
            logic signed [PW-1:0] shifted;
            logic [PW-DATA_W:0]   hi;
            shifted = acc_q >>> sh_amt;
            hi      = shifted[PW-1:DATA_W-1];
            if (&hi || ~|hi)
                res = shifted[DATA_W-1:0];
            else
                res = shifted[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`else
        res = DATA_W'(acc_q >>> sh_amt);
`endif
    end

    // streaming modes update every product, accumulating modes once per period
    assign out_upd = acc_v_q && (!fns_q[1] || acc_last_q);

    // output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flow_out_q <= '0;
        else if (out_upd) flow_out_q <= res;
    end

endmodule

// File: tb/tb_xmuladd.sv
// tb_xmuladd: directed scoreboard bench for xmuladd (DATA_W=32, PIPE=2).
module tb_xmuladd;
  localparam int DATA_W = 32;
  localparam int N_SRC  = 16;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 10;
  localparam int PIPE   = 2;

  logic                    clk;
  logic                    rst;
  logic                    run;
  logic                    done;
  logic [N_SRC*DATA_W-1:0] flow_in;
  logic [DATA_W-1:0]       flow_out;
  logic [SEL_W-1:0]        conf_sela, conf_selb;
  logic [1:0]              conf_fns;
  logic [5:0]              conf_shift;
  logic [CNT_W-1:0]        conf_per, conf_iter, conf_delay;
  logic [1:0]              dbg_state;

  xmuladd #(
    .DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W), .PIPE(PIPE)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .done(done),
    .flow_in(flow_in), .flow_out(flow_out),
    .conf_sela(conf_sela), .conf_selb(conf_selb), .conf_fns(conf_fns),
    .conf_shift(conf_shift), .conf_per(conf_per), .conf_iter(conf_iter),
    .conf_delay(conf_delay), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial rst = 1'b1;

  // scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  int                due_q[$];
  logic [DATA_W-1:0] exp_hold;
  int                done_due;
  int                cyc;
  int                a_list[$];
  int                b_list[$];
  int                n_assert;
  int                n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // advance one edge, then compare outputs against the scoreboard
  task automatic step();
    int dd;
    @(posedge clk);
    cyc++;
    #1;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_hold = exp_q.pop_front();
      dd = due_q.pop_front();
    end
    check("flow_out", flow_out, exp_hold);
    check("done", 32'(done), 32'(cyc == done_due));
  endtask

  function automatic logic [31:0] model_out(input longint acc, input int fns, input int shift);
    longint sh;
    int     amt;
    amt = (fns == 1) ? 31 + shift : shift;
    sh  = acc >>> amt;
`ifdef XMULADD_SAT_EN
    if (sh > 64'sd2147483647) return 32'h7fffffff;
    if (sh < -64'sd2147483648) return 32'h80000000;
`endif
    return sh[31:0];
  endfunction

  task automatic fill_bus();
    for (int s = 0; s < N_SRC; s++) flow_in[s*DATA_W +: DATA_W] = $urandom;
  endtask

  // drive one run; operands come from a_list/b_list
  task automatic run_job(input int sela, input int selb, input int fns, input int shift,
                         input int per, input int iter, input int delay,
                         input bit poke, input int abort_at);
    int     t, n, first_e, k, pos;
    longint acc, p;
    t       = cyc + 1;
    n       = per * iter;
    first_e = t + 1 + delay;
    acc     = 0;
    for (int i = 0; i < n; i++) begin
      p   = longint'(a_list[i]) * longint'(b_list[i]);
      pos = i % per;
      if (fns == 2) acc = (pos == 0) ? p : acc + p;
      else if (fns == 3) acc = (pos == 0) ? -p : acc - p;
      else acc = p;
      if (fns < 2 || pos == per - 1) begin
        due_q.push_back(first_e + i + PIPE + 2);
        exp_q.push_back(model_out(acc, fns, shift));
      end
    end
    done_due   = t + delay + n + PIPE + 2;
    conf_sela  = SEL_W'(sela);
    conf_selb  = SEL_W'(selb);
    conf_fns   = 2'(fns);
    conf_shift = 6'(shift);
    conf_per   = CNT_W'(per);
    conf_iter  = CNT_W'(iter);
    conf_delay = CNT_W'(delay);
    run        = 1'b1;
    while (cyc < done_due) begin
      fill_bus();
      k = cyc + 1 - first_e;
      if (k >= 0 && k < n) begin
        flow_in[sela*DATA_W +: DATA_W] = a_list[k];
        flow_in[selb*DATA_W +: DATA_W] = b_list[k];
      end
      step();
      run = 1'b0;
      if (poke && cyc == first_e + 1) begin
        run       = 1'b1;
        conf_fns  = 2'd2;
        conf_per  = CNT_W'(1);
        conf_sela = SEL_W'(0);
      end
      if (poke && cyc == first_e + 2) check("state_run_after_poke", 32'(dbg_state), 32'd2);
      if (abort_at > 0 && cyc == t + abort_at) begin
        #2;
        rst = 1'b0;
        #1;
        due_q.delete();
        exp_q.delete();
        exp_hold = '0;
        done_due = -1;
        check("abort_flow_out", flow_out, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        step();
        step();
        rst = 1'b1;
        return;
      end
    end
    check("state_idle_after_done", 32'(dbg_state), 32'd0);
  endtask

  task automatic load_const(input int n, input int a, input int b);
    a_list.delete();
    b_list.delete();
    for (int i = 0; i < n; i++) begin
      a_list.push_back(a);
      b_list.push_back(b);
    end
  endtask

  task automatic load_rand(input int n, input bit wide);
    a_list.delete();
    b_list.delete();
    for (int i = 0; i < n; i++) begin
      if (wide) begin
        a_list.push_back(int'($urandom));
        b_list.push_back(int'($urandom));
      end else begin
        a_list.push_back(int'($urandom_range(0, 2000)) - 1000);
        b_list.push_back(int'($urandom_range(0, 2000)) - 1000);
      end
    end
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    cyc        = 0;
    done_due   = -1;
    exp_hold   = '0;
    run        = 1'b0;
    flow_in    = '0;
    conf_sela  = '0;
    conf_selb  = '0;
    conf_fns   = '0;
    conf_shift = '0;
    conf_per   = '0;
    conf_iter  = '0;
    conf_delay = '0;

    // reset
    #2 rst = 1'b0;
    step();
    step();
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    step();

    // MUL_LO 3 * -5, per=1 iter=4
    load_const(4, 3, -5);
    run_job(1, 2, 0, 0, 1, 4, 0, 1'b0, 0);
    check("mul_lo_value", flow_out, 32'hFFFFFFF1);

    // MAC per=4 iter=2, a=1..8, b=2 -> 20 then 52
    a_list.delete();
    b_list.delete();
    for (int i = 1; i <= 8; i++) begin
      a_list.push_back(i);
      b_list.push_back(2);
    end
    run_job(3, 4, 2, 0, 4, 2, 0, 1'b0, 0);
    check("mac_final", flow_out, 32'd52);

    // MUL_HI 0.5 * 0.5 in Q31
    load_const(2, 32'h40000000, 32'h40000000);
    run_job(5, 5, 1, 0, 1, 2, 0, 1'b0, 0);
    check("mul_hi_value", flow_out, 32'h20000000);

    // MAC overflow of DATA_W: saturates or wraps
    load_const(2, 32'h7FFFFFFF, 32'h7FFFFFFF);
    run_job(6, 7, 2, 0, 2, 1, 0, 1'b0, 0);
`ifdef XMULADD_SAT_EN
    check("mac_sat", flow_out, 32'h7FFFFFFF);
`else
    check("mac_wrap", flow_out, 32'h00000002);
`endif

    // MSUB with shift, small random operands
    load_rand(6, 1'b0);
    run_job(8, 9, 3, 2, 3, 2, 0, 1'b0, 0);

    // MUL_LO with shift and delay, wide random operands
    load_rand(6, 1'b1);
    run_job(10, 11, 0, 4, 2, 3, 2, 1'b0, 0);

    // MUL_HI with extra shift, wide random operands
    load_rand(3, 1'b1);
    run_job(0, 3, 1, 1, 1, 3, 0, 1'b0, 0);

    // delay=3, ignored run in RUN, reset mid-run
    load_rand(12, 1'b0);
    run_job(12, 13, 0, 0, 4, 3, 3, 1'b1, 10);

    // normal run after the abort
    load_rand(4, 1'b0);
    run_job(14, 15, 2, 0, 2, 2, 0, 1'b0, 0);

    // per=0: no samples, output unchanged, done after PIPE+2
    load_const(0, 0, 0);
    run_job(1, 2, 0, 0, 0, 5, 0, 1'b0, 0);

    // iter=0 with delay
    run_job(1, 2, 2, 0, 3, 0, 2, 1'b0, 0);

    // idle tail: output holds, no spurious done
    fill_bus();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/xmuladd.md
# xmuladd

Parametrised pipelined multiply / multiply-accumulate functional unit for the Versat data engine, successor to the fixed single-cycle multiplier FU. It selects two operands from the flow bus and multiplies them through a configurable number of pipeline stages. It either streams the scaled products or accumulates them over programmable periods. A run/done handshake and a start delay let the controller align it with other FUs in a schedule.

## Interface
- DATA_W, 32, operand and output width
- N_SRC, 16, number of DATA_W sources on the flow bus
- SEL_W, 4, selector width, equal to clog2(N_SRC)
- CNT_W, 10, width of the period, iteration and delay counters
- PIPE, 2, product register stages after the operand registers; legal range 1..4
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  start pulse; sampled only in IDLE, latches all conf_* inputs
- done  out  1  one-cycle pulse when the last result of a run is on flow_out
- flow_in  in  N_SRC*DATA_W  flow bus; source i occupies bits [i*DATA_W +: DATA_W]
- flow_out  out  DATA_W  registered result
- conf_sela, conf_selb  in  SEL_W  operand source selects
- conf_fns  in  2  function: 0 MUL_LO, 1 MUL_HI, 2 MAC, 3 MSUB
- conf_shift  in  6  arithmetic right shift applied before output; must be ≤ 2*DATA_W-1
- conf_per  in  CNT_W  products per accumulation period
- conf_iter  in  CNT_W  number of periods per run
- conf_delay  in  CNT_W  idle cycles between run and the first operand sample

## Operation
- The FSM has four states: IDLE, DELAY, RUN and DRAIN. Reset drives it to IDLE.
  - IDLE: on run=1, latch the configuration. Go to DELAY if conf_delay>0, otherwise go to RUN.
  - DELAY: decrement the delay counter; at 1, go to RUN.
  - RUN: sample one operand pair per cycle. The period counter runs 0..per-1 and the iteration counter runs 0..iter-1. After the sample with both counters at maximum, go to DRAIN.
  - DRAIN: wait PIPE+2 cycles, then pulse done and go to IDLE.
- run outside IDLE is ignored. Configuration changes outside IDLE have no effect.
- If per=0 or iter=0, RUN is skipped: the FSM goes straight to DRAIN, no samples are taken, and flow_out is unchanged.
- Datapath: operand registers, then PIPE stages carrying the 2*DATA_W signed product p, then an accumulator stage, then the flow_out register. Each stage carries a valid bit and a last-of-period flag.
- Accumulator: 2*DATA_W signed.
  - MAC: acc = p on the first product of a period, acc + p otherwise.
  - MSUB: acc = -p on the first product, acc - p otherwise.
  - MUL modes: acc = p.
- Output value:
  - MUL_LO: (acc >>> shift)[DATA_W-1:0]
  - MUL_HI: (acc >>> (DATA_W-1+shift))[DATA_W-1:0] (fractional Q format)
  - MAC/MSUB: (acc >>> shift)[DATA_W-1:0]
- Update rule for flow_out:
  - MUL modes: updates on every valid product.
  - MAC/MSUB: updates only on the last product of each period and holds in between.
  - Outside RUN/DRAIN, flow_out holds its last value.
- Reset values: flow_out=0, done=0, state IDLE, all counters, valid bits and the accumulator 0.
- Asserting rst mid-run aborts the run immediately. No done pulse is produced.

## Timing
- If run is sampled at edge T, the first operand sample occurs at edge T+1+delay.
- Sample latency: a sample taken at edge S appears on flow_out after edge S+PIPE+2.
- Throughput is one product per cycle. Consecutive periods have no bubble.
- done is set at the edge that registers the final result, so it is high in the same cycle the final flow_out value is first visible. It is low otherwise.
- The earliest next run is accepted in the cycle after done.

## Configuration
- XMULADD_SAT_EN
  - Defined: before truncation to DATA_W, the shifted value saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Undefined: the value wraps by plain truncation.
  - The accumulator itself always wraps at 2*DATA_W.

## Test plan
- MUL_LO, DATA_W=32, PIPE=2, src1=3, src2=-5, per=1, iter=4, delay=0, run at edge 0 -> flow_out=-15 (0xFFFFFFF1) after edge 5; done high in the cycle after edge 8; IDLE afterwards.
- MAC, per=4, iter=2, shift=0, conf_sela stream a=1..8, b=2 -> flow_out=20 after the 4th product's latency, holds, then 52; a single done pulse accompanies 52.
- MUL_HI, a=b=0x40000000, shift=0 -> flow_out=0x20000000.
- MAC, per=2, a=b=0x7FFFFFFF, shift=0 -> flow_out=0x7FFFFFFF with XMULADD_SAT_EN, 0x00000002 without.
- delay=3, then a run pulse while in RUN, then rst low mid-run:
  - The first sample occurs at edge 4.
  - The second run is ignored.
  - Reset drives flow_out=0 and done=0 at once, with no done pulse.
  - A following run completes normally.
- per=0, iter=5 -> no sample taken, flow_out unchanged, done pulses PIPE+2 cycles after run.
